vga_frame_receiver: RTL and testbench

VGA_FRAME_RECEIVER -- requirements
Module: vga_frame_receiver

---
 rtl/vga_timing_pkg.sv | 40 ++++
 rtl/vga_edge_counter.sv | 59 +++++
 rtl/vga_frame_receiver.sv | 195 +++++++++++++++++++
 tb/tb_vga_frame_receiver.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480 timing constants, receiver FSM state type and a
// saturating-counter helper. The timing generator and the frame receiver
// both import this package so the two sides agree on the line/frame layout.
// A line starts at the hSync falling edge: sync, back porch, active, front
// porch. A frame starts at the vSync falling edge in the same order.
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Width of the horizontal and vertical position counters
  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2
  } rx_state_t;

  // Increment that sticks at all-ones instead of wrapping back to zero
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_edge_counter.sv
// Sync falling-edge detector plus saturating position counter. Used once for
// the horizontal position (inc_i tied high) and once for the vertical
// position (inc_i = horizontal sync edge).
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   en_i          pixel strobe; history and counter only move when high
//   sync_i        active-low sync level sampled on en_i
//   inc_i         count enable when no falling edge is seen
//   fall_o        falling edge on this sample (previous 1, current 0)
//   cnt_q_o       counter value before this sample
//   cnt_d_o       counter value after this sample
module vga_edge_counter
  import vga_timing_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             inc_i,
  output logic             fall_o,
  output logic [CNT_W-1:0] cnt_q_o,
  output logic [CNT_W-1:0] cnt_d_o
);

  logic             sync_prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign fall_o  = en_i & sync_prev_q & ~sync_i;
  assign cnt_q_o = cnt_q;
  assign cnt_d_o = cnt_d;

  // Next count: the edge clears, otherwise count (saturating) when enabled
  always_comb begin
    cnt_d = cnt_q;
    if (fall_o) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en_i && inc_i) begin
      cnt_d = sat_inc(cnt_q);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Sync history starts high so a sync already low after reset reads as an edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_prev_q <= 1'b1;
      cnt_q       <= {CNT_W{1'b0}};
    end else if (en_i) begin
      sync_prev_q <= sync_i;
      cnt_q       <= cnt_d;
    end else begin
      sync_prev_q <= sync_prev_q;
      cnt_q       <= cnt_q;
    end
  end

endmodule

// File: rtl/vga_frame_receiver.sv
// VGA frame receiver: recovers the pixel stream from hSync/vSync/rgb sampled
// on the pixel strobe, locks onto the timing after one clean frame, flags
// malformed lines/frames, and reports a per-frame pixel checksum and count.
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   pix_en                one-cycle pixel strobe
//   hSync, vSync, rgb     active-low syncs and {R,G,B} pixel data
//   pix_valid/x/y/rgb     recovered active pixel, one clk after its sample
//   locked                timing locked
//   frame_done            pulse at the start of the next frame after a good one
//   frame_cnt, frame_sum  completed frames and 16-bit sum of their rgb values
//   line_err, frame_err   pulses when lock is lost through a bad line/frame
module vga_frame_receiver
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [11:0] rgb,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic [15:0] frame_sum,
  output logic        line_err,
  output logic        frame_err
);

  localparam logic [9:0] H_TOT_C   = 10'(H_SYNC + H_BP + H_ACTIVE + H_FP);
  localparam logic [9:0] H_LAST_C  = 10'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [9:0] H_START_C = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_END_C   = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] V_TOT_C   = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP);
  localparam logic [9:0] V_LAST_C  = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
  localparam logic [9:0] V_START_C = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_END_C   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [8:0] V_OFS_C   = 9'(V_SYNC + V_BP);

  rx_state_t   state_q;
  logic        align_ok_q;
  logic [15:0] sum_q;
  logic        pix_valid_q;
  logic [9:0]  pix_x_q;
  logic [8:0]  pix_y_q;
  logic [11:0] pix_rgb_q;
  logic        locked_q;
  logic        frame_done_q;
  logic [15:0] frame_cnt_q;
  logic [15:0] frame_sum_q;
  logic        line_err_q;
  logic        frame_err_q;

  logic        h_fall_s;
  logic        v_fall_s;
  logic [9:0]  h_cnt_q;
  logic [9:0]  h_cnt_d;
  logic [9:0]  v_cnt_q;
  logic [9:0]  v_cnt_d;
  logic        line_err_s;
  logic        frame_err_s;
  logic        in_win_s;

  vga_edge_counter u_h_cnt (
    .clk_i   (clk),
    .rst_i   (reset),
    .en_i    (pix_en),
    .sync_i  (hSync),
    .inc_i   (1'b1),
    .fall_o  (h_fall_s),
    .cnt_q_o (h_cnt_q),
    .cnt_d_o (h_cnt_d)
  );

  // Vertical edge clears first; otherwise lines are counted on hSync edges
  vga_edge_counter u_v_cnt (
    .clk_i   (clk),
    .rst_i   (reset),
    .en_i    (pix_en),
    .sync_i  (vSync),
    .inc_i   (h_fall_s),
    .fall_o  (v_fall_s),
    .cnt_q_o (v_cnt_q),
    .cnt_d_o (v_cnt_d)
  );

  // An overlong line/frame is flagged once, on the sample that first reaches
  // the total; the late edge that eventually follows is flagged again.
  assign line_err_s  = pix_en & ((h_fall_s & (h_cnt_q != H_LAST_C)) |
                                 (~h_fall_s & (h_cnt_d == H_TOT_C) & (h_cnt_q != H_TOT_C)));
  assign frame_err_s = pix_en & ((v_fall_s & (v_cnt_q != V_LAST_C)) |
                                 (~v_fall_s & (v_cnt_d == V_TOT_C) & (v_cnt_q != V_TOT_C)));
  assign in_win_s    = (h_cnt_d >= H_START_C) && (h_cnt_d < H_END_C) &&
                       (v_cnt_d >= V_START_C) && (v_cnt_d < V_END_C);

  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_rgb    = pix_rgb_q;
  assign locked     = locked_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign frame_sum  = frame_sum_q;
  assign line_err   = line_err_q;
  assign frame_err  = frame_err_q;

  // Lock FSM with registered pixel stream, error pulses and frame statistics
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_SEARCH;
      align_ok_q   <= 1'b0;
      sum_q        <= 16'd0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= 10'd0;
      pix_y_q      <= 9'd0;
      pix_rgb_q    <= 12'd0;
      locked_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 16'd0;
      frame_sum_q  <= 16'd0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      if (pix_en) begin
        case (state_q)
          ST_SEARCH: begin
            if (v_fall_s) begin
              state_q    <= ST_ALIGN;
              align_ok_q <= 1'b1;
            end
          end
          ST_ALIGN: begin
            // Errors seen on the closing vSync edge still count against the frame
            if (v_fall_s) begin
              align_ok_q <= 1'b1;
              if (align_ok_q && !line_err_s && !frame_err_s) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
              end
            end else if (line_err_s || frame_err_s) begin
              align_ok_q <= 1'b0;
            end
          end
          ST_LOCKED: begin
            if (line_err_s || frame_err_s) begin
              state_q     <= ST_SEARCH;
              locked_q    <= 1'b0;
              line_err_q  <= line_err_s;
              frame_err_q <= frame_err_s;
            end else begin
              if (v_fall_s) begin
                frame_done_q <= 1'b1;
                frame_sum_q  <= sum_q;
                frame_cnt_q  <= frame_cnt_q + 16'd1;
              end
              if (in_win_s) begin
                pix_valid_q <= 1'b1;
                pix_x_q     <= h_cnt_d - H_START_C;
                pix_y_q     <= v_cnt_d[8:0] - V_OFS_C;
                pix_rgb_q   <= rgb;
                sum_q       <= sum_q + {4'd0, rgb};
              end
            end
          end
          default: begin
            state_q  <= ST_SEARCH;
            locked_q <= 1'b0;
          end
        endcase
        // Every frame boundary starts a fresh checksum, whatever the state
        if (v_fall_s) begin
          sum_q <= 16'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_receiver.sv
// Randomized bench for vga_frame_receiver using a reduced timing (16x11
// samples per frame) so many frames fit in a short run. A frame-level model
// tracks lock state, expected error pulses, frame statistics and the queue of
// pixels the receiver must emit.
module tb_vga_frame_receiver;

  localparam int HA = 8;
  localparam int HFP = 2;
  localparam int HS = 3;
  localparam int HB = 3;
  localparam int HT = HA + HFP + HS + HB;
  localparam int VA = 6;
  localparam int VFP = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int VT = VA + VFP + VS + VB;
  localparam int S_SEARCH = 0;
  localparam int S_ALIGN = 1;
  localparam int S_LOCKED = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic        hSync;
  logic        vSync;
  logic [11:0] rgb;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [11:0] pix_rgb;
  logic        locked;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic [15:0] frame_sum;
  logic        line_err;
  logic        frame_err;

  int n_chk = 0;
  int n_pass = 0;
  int n_done = 0;
  int n_lerr = 0;
  int n_ferr = 0;

  // reference model
  int          m_state;
  bit          m_clean;
  logic [15:0] m_sum;
  logic [15:0] m_fsum;
  logic [15:0] m_cnt;
  int          e_done = 0;
  int          e_lerr = 0;
  int          e_ferr = 0;
  logic [30:0] exp_q[$];

  vga_frame_receiver #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .hSync(hSync), .vSync(vSync), .rgb(rgb),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .locked(locked), .frame_done(frame_done), .frame_cnt(frame_cnt), .frame_sum(frame_sum),
    .line_err(line_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: counts pulses and matches every valid pixel against the model
  initial begin
    logic [30:0] e;
    forever begin
      @(negedge clk);
      if (frame_done) n_done++;
      if (line_err) n_lerr++;
      if (frame_err) n_ferr++;
      if (pix_valid) begin
        if (exp_q.size() == 0) begin
          check_val("pix_unexpected", 64'(pix_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("pix", 64'({pix_x, pix_y, pix_rgb}), 64'(e));
        end
      end
    end
  end

  task automatic pix(input logic hs, input logic vs, input logic [11:0] c);
    @(negedge clk);
    hSync = hs; vSync = vs; rgb = c; pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check_val("rst_pix", 64'({pix_valid, pix_x, pix_y, pix_rgb}), 64'd0);
    check_val("rst_ctl", 64'({locked, frame_done, line_err, frame_err, frame_cnt, frame_sum}), 64'd0);
  endtask

  task automatic model_reset();
    m_state = S_SEARCH;
    m_clean = 1'b0;
    m_sum = 16'd0;
    m_fsum = 16'd0;
    m_cnt = 16'd0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_pause();
    repeat (1000) @(negedge clk);
    check_val("pause_lock", 64'(locked), 64'(m_state == S_LOCKED));
  endtask

  // Lock rules applied at each vSync edge, based on the frame just finished
  task automatic model_frame_start();
    case (m_state)
      S_SEARCH: m_state = S_ALIGN;
      S_ALIGN: if (m_clean) m_state = S_LOCKED;
      default: begin
        if (m_clean) begin
          e_done++;
          m_cnt = m_cnt + 16'd1;
          m_fsum = m_sum;
        end else begin
          e_ferr++;
          m_state = S_SEARCH;
        end
      end
    endcase
    m_sum = 16'd0;
  endtask

  task automatic checkpoint();
    #1;
    check_val("locked", 64'(locked), 64'(m_state == S_LOCKED));
    check_val("frame_cnt", 64'(frame_cnt), 64'(m_cnt));
    check_val("frame_sum", 64'(frame_sum), 64'(m_fsum));
    check_val("done_pulses", 64'(n_done), 64'(e_done));
    check_val("line_err_pulses", 64'(n_lerr), 64'(e_lerr));
    check_val("frame_err_pulses", 64'(n_ferr), 64'(e_ferr));
    check_val("pix_backlog", 64'(exp_q.size()), 64'd0);
  endtask

  // nl lines; line long_l carries one extra pixel; optional reset / pause
  task automatic send_frame(input int nl, input int long_l, input bit const_c,
                            input int rst_l, input int pause_l);
    int len;
    bit act;
    logic [11:0] c;
    logic [9:0] ex;
    logic [8:0] ey;
    for (int l = 0; l < nl; l++) begin
      len = (l == long_l) ? HT + 1 : HT;
      for (int h = 0; h < len; h++) begin
        if (l == 0 && h == 0) model_frame_start();
        if (l == rst_l && h == HS + HB + HA / 2) do_reset();
        if (l == pause_l && h == 0) do_pause();
        if (m_state == S_LOCKED && (h == HT || (h == 0 && l == VT))) begin
          if (h == HT) e_lerr++;
          else e_ferr++;
          m_state = S_SEARCH;
        end
        act = (h >= HS + HB) && (h < HS + HB + HA) && (l >= VS + VB) && (l < VS + VB + VA);
        c = (act && const_c) ? 12'h001 : 12'($urandom);
        if (act && m_state == S_LOCKED) begin
          ex = 10'(h - (HS + HB));
          ey = 9'(l - (VS + VB));
          exp_q.push_back({ex, ey, c});
          m_sum = m_sum + {4'd0, c};
        end
        pix(h >= HS, l >= VS, c);
        if (l == 0 && h == 0) checkpoint();
      end
    end
    m_clean = (nl == VT) && (long_l < 0);
  endtask

  initial begin
    int r;
    reset = 1'b1; pix_en = 1'b0; hSync = 1'b1; vSync = 1'b1; rgb = 12'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;

    send_frame(VT, -1, 1'b0, -1, -1);   // SEARCH -> ALIGN
    send_frame(VT, -1, 1'b1, -1, -1);   // locked, constant rgb 1
    send_frame(VT, -1, 1'b0, -1, 5);    // pause mid-frame
    check_val("sum_const", 64'(frame_sum), 64'(16'(HA * VA)));
    send_frame(VT, 5, 1'b0, -1, -1);    // long line while locked
    send_frame(VT - 1, -1, 1'b0, -1, -1); // short frame while aligning
    send_frame(VT, -1, 1'b0, -1, -1);
    send_frame(VT, -1, 1'b0, 7, -1);    // reset mid-frame while locked
    send_frame(VT, -1, 1'b0, -1, -1);
    send_frame(VT - 1, -1, 1'b0, -1, -1); // short frame while locked
    send_frame(VT, -1, 1'b0, -1, -1);
    send_frame(VT, -1, 1'b0, -1, -1);
    send_frame(VT + 1, -1, 1'b0, -1, -1); // long frame while locked
    for (int i = 0; i < 14; i++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0: send_frame(VT, int'($urandom_range(0, VT - 1)), 1'b0, -1, -1);
        1: send_frame(VT - 1, -1, 1'b0, -1, -1);
        2: send_frame(VT + 1, -1, 1'b0, -1, -1);
        default: send_frame(VT, -1, 1'b0, -1, -1);
      endcase
    end
    send_frame(1, -1, 1'b0, -1, -1);    // closing vSync edge
    repeat (4) @(negedge clk);
    check_val("final_backlog", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
